div_seq: RTL

- Multi-cycle sequencer for the shared 32-bit integer divider behind DIV/DIVU in the EX stage.
- Accepts a divide request from the ALU control path, runs a 32-iteration restoring division, and applies the signed fix-up.
- Holds the pipeline stalled until the result is ready, then presents {remainder, quotient} for the HI/LO write.
- Supports annulment when the issuing instruction is flushed.

---
 rtl/div_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/div_seq.sv
// div_seq: multi-cycle sequencer for the shared DIV/DIVU divider in EX.
// Runs a WIDTH-iteration restoring division on operand magnitudes and
// applies the sign fix-up when the result is written. The pipeline is held
// stalled until {remainder, quotient} is ready for the HI/LO write.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for a request; operands are latched on acceptance
// DIVZERO | divisor was zero; one cycle, then END with a zero result
// ON      | one restoring-division iteration per cycle, cnt counts up
// END     | result_o valid, ready_o high until start_i is released
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start_i,
    input  logic                 signed_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stall_o
);

    typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(WIDTH - 1);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  quot, rem, divisor;
    logic              sign_q, sign_r;

    logic              accept;
    logic              op1_neg, op2_neg;
    logic [WIDTH-1:0]  op1_abs, op2_abs;
    logic [WIDTH:0]    shifted, trial;
    logic              borrow, last;
    logic [WIDTH-1:0]  quot_nxt, rem_nxt, quot_fix, rem_fix;

    // Operand magnitudes and one restoring-division step on the held state.
    // The dividend is shifted out of quot while quotient bits shift in.
    always_comb begin
        op1_neg  = signed_i & opdata1_i[WIDTH-1];
        op2_neg  = signed_i & opdata2_i[WIDTH-1];
        op1_abs  = op1_neg ? (~opdata1_i) + ONE : opdata1_i;
        op2_abs  = op2_neg ? (~opdata2_i) + ONE : opdata2_i;
        shifted  = {rem, quot[WIDTH-1]};
        trial    = shifted - {1'b0, divisor};
        borrow   = trial[WIDTH];
        rem_nxt  = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
        quot_nxt = {quot[WIDTH-2:0], ~borrow};
        // sign_q/sign_r are only ever set in signed mode, so they carry signed_i
        quot_fix = sign_q ? (~quot_nxt) + ONE : quot_nxt;
        rem_fix  = sign_r ? (~rem_nxt) + ONE : rem_nxt;
        last     = (cnt == CNT_TC);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode, acceptance and combinational stall request.
    always_comb begin
        state_nxt = state;
        stall_o   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (start_i && !annul_i) begin
                    accept    = 1'b1;
                    stall_o   = 1'b1;
                    state_nxt = (opdata2_i == '0) ? DIVZERO : ON;
                end
            end
            DIVZERO: begin
                if (annul_i) begin
                    state_nxt = IDLE;
                end else begin
                    stall_o   = 1'b1;
                    state_nxt = END;
                end
            end
            ON: begin
                if (annul_i) begin
                    state_nxt = IDLE;
                end else begin
                    stall_o = 1'b1;
                    if (last) state_nxt = END;
                end
            end
            END: begin
                if (annul_i || !start_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result and ready registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt      <= '0;
            quot     <= '0;
            rem      <= '0;
            divisor  <= '0;
            sign_q   <= 1'b0;
            sign_r   <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    if (accept) begin
                        quot    <= op1_abs;
                        rem     <= '0;
                        divisor <= op2_abs;
                        sign_q  <= op1_neg ^ op2_neg;
                        sign_r  <= op1_neg;
                        cnt     <= '0;
                    end
                end
                DIVZERO: begin
                    result_o <= '0;
                    ready_o  <= !annul_i;
                end
                ON: begin
                    if (annul_i) begin
                        cnt      <= '0;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        quot <= quot_nxt;
                        rem  <= rem_nxt;
                        cnt  <= cnt + CNT_ONE;
                        if (last) begin
                            result_o <= {rem_fix, quot_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                END: begin
                    if (annul_i || !start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule
